fetch_control: RTL and testbench
================================

# fetch_control

Instruction-fetch sequencer for the core's front end. Owns the architectural PC and drives the instruction-memory request/response handshake. Presents fetched instructions to the decode stage register and applies redirects from the branch unit (should_branch plus computed target) with a one-cycle flush pulse. Allows at most one outstanding memory request and discards responses that a redirect has made stale.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset; must be word aligned
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  branch unit requests a PC change this cycle
- redirect_target  in  32  new PC, valid with redirect_valid
- stall  in  1  decode cannot accept; hold the current if_* outputs
- imem_req  out  1  fetch request (combinational, see Operation)
- imem_addr  out  32  request address; equals the PC register
- imem_ready  in  1  memory accepts the request at this edge when imem_req=1
- imem_rvalid  in  1  response valid; earliest one cycle after acceptance
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- if_valid  out  1  if_pc/if_instr hold a live instruction
- if_pc  out  32  PC of the presented instruction
- if_instr  out  32  presented instruction
- flush  out  1  one-cycle pulse: decode must squash its contents
- misaligned  out  1  sticky error: a redirect target had bits [1:0] != 0

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALT. Internal: pc (32), kill (1).
- Reset (async): state=IDLE, pc=RESET_PC, kill=0, if_valid=0, if_pc=0, if_instr=0, flush=0, misaligned=0. imem_req is 0 in every state except REQ.
- IDLE -> REQ unconditionally on the next edge. imem_rvalid is ignored in IDLE and REQ.
- REQ: imem_req = !redirect_valid. If redirect_valid, take the redirect and stay in REQ. Otherwise, if imem_ready, go to WAIT.
- WAIT, with imem_rvalid:
  - If kill or redirect_valid: discard the data, clear kill, go to REQ. Apply the redirect if it is present.
  - Otherwise: if_valid<=1, if_pc<=pc, if_instr<=imem_rdata, pc<=pc+4, go to HOLD.
- WAIT, without imem_rvalid: on redirect_valid, take the redirect, set kill=1, stay in WAIT.
- HOLD: redirect_valid has priority over stall. On redirect, take the redirect, clear if_valid, go to REQ. Else if !stall, the instruction is consumed at this edge: clear if_valid, go to REQ. Else hold all outputs.
- Take redirect: if redirect_target[1:0]==0, then pc<=redirect_target and flush<=1 for the next cycle. Otherwise misaligned<=1, if_valid<=0, go to HALT, no flush.
- HALT: no requests, inputs ignored, exit only via reset_n.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000, with no error.
- flush is a registered pulse. It is high exactly one cycle after each taken redirect. Back-to-back redirects give back-to-back pulses.

## Timing
- First fetch: reset_n released before edge 0. IDLE in cycle 1. REQ in cycle 2 with imem_addr=RESET_PC.
- Accept with imem_ready=1 at the end of cycle 2; response arrives in cycle 3; if_valid is high from cycle 4.
- Steady state with zero-wait memory and stall=0: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect in cycle N: pc is updated and flush=1 in cycle N+1. A new request issues in N+1 from REQ/HOLD, or after the stale response when in WAIT.
- Reset asserted mid-WAIT: outputs clear immediately. A late imem_rvalid after release is ignored.
- if_* outputs change only at edges where if_valid=0, or where they are consumed or redirected.

## Test plan
- Reset/first fetch: RESET_PC=0x100, imem_ready=1, rvalid one cycle after accept, rdata=0x00500093 -> imem_addr=0x100 in cycle 2; if_valid=1, if_pc=0x100, if_instr=0x00500093 in cycle 4; next request at 0x104.
- Stall hold: hold stall=1 for 5 cycles in HOLD -> if_* stable, imem_req=0 throughout; first request at pc+4 one cycle after stall drops.
- Redirect during WAIT: redirect to 0x200 while waiting, rvalid 2 cycles later -> kill set, flush one cycle, response discarded (if_valid stays 0), next imem_addr=0x200.
- Simultaneous redirect and stall in HOLD: target 0x40, stall=1 -> if_valid cleared, flush pulse, imem_addr=0x40; redirect wins.
- Misaligned target 0x202 -> misaligned=1 sticky, no flush, imem_req=0 forever; reset_n low clears misaligned and restarts at RESET_PC.
- Wrap: redirect to 0xFFFF_FFFC, fetch completes -> next imem_addr=0x0000_0000.

Source files
------------

// File: rtl/fetch_control.sv
// -----------------------------------------------------------------------------
// fetch_control
//
// Instruction-fetch sequencer for the core front end. Owns the architectural
// PC, runs the single-outstanding instruction-memory handshake, presents each
// fetched word to the decode stage register and applies branch-unit redirects
// with a one-cycle flush pulse. A response that a redirect has made stale is
// dropped rather than presented.
//
// Parameters
//   RESET_PC           PC of the first fetch after reset (word aligned)
//
// Ports
//   clock_i            rising-edge clock
//   reset_n_i          asynchronous active-low reset
//   redirect_valid_i   branch unit requests a PC change this cycle
//   redirect_target_i  new PC, qualified by redirect_valid_i
//   stall_i            decode cannot accept; hold the if_* outputs
//   imem_req_o         fetch request (combinational, only in the request state)
//   imem_addr_o        request address, always the PC register
//   imem_ready_i       memory accepts the request at this edge
//   imem_rvalid_i      response valid
//   imem_rdata_i       instruction word, qualified by imem_rvalid_i
//   if_valid_o         if_pc_o / if_instr_o hold a live instruction
//   if_pc_o            PC of the presented instruction
//   if_instr_o         presented instruction word
//   flush_o            one-cycle pulse after each taken redirect
//   misaligned_o       sticky: a redirect target was not word aligned
// -----------------------------------------------------------------------------
module fetch_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        flush_o,
    output logic        misaligned_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        flush_q, flush_d;
    logic        misaligned_q, misaligned_d;

    // Redirect targets must be word aligned; anything else halts the fetcher.
    logic        target_aligned;
    logic [31:0] pc_plus4;

    assign target_aligned = (redirect_target_i[1:0] == 2'b00);
    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 -> 0x0000_0000.
    assign pc_plus4       = pc_q + 32'd4;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 32'h0000_0000;
            if_instr_q   <= 32'h0000_0000;
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            flush_q      <= flush_d;
            misaligned_q <= misaligned_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and request logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        flush_d      = 1'b0;          // pulse: high only after a taken redirect
        misaligned_d = misaligned_q;
        imem_req_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                // A redirect this cycle would make the current address stale,
                // so no request is offered while one is present.
                imem_req_o = !redirect_valid_i;
                if (redirect_valid_i) begin
                    if (target_aligned) begin
                        pc_d    = redirect_target_i;
                        flush_d = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        misaligned_d = 1'b1;
                        if_valid_d   = 1'b0;
                        state_d      = S_HALT;
                    end
                end else if (imem_ready_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem_rvalid_i) begin
                    if (kill_q || redirect_valid_i) begin
                        // Response belongs to the old path: drop it and
                        // refetch from the (possibly just updated) PC.
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                        if (redirect_valid_i) begin
                            if (target_aligned) begin
                                pc_d    = redirect_target_i;
                                flush_d = 1'b1;
                            end else begin
                                misaligned_d = 1'b1;
                                if_valid_d   = 1'b0;
                                state_d      = S_HALT;
                            end
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = imem_rdata_i;
                        pc_d       = pc_plus4;
                        state_d    = S_HOLD;
                    end
                end else if (redirect_valid_i) begin
                    // The request in flight is now stale; remember to drop
                    // its response when it eventually arrives.
                    if (target_aligned) begin
                        pc_d    = redirect_target_i;
                        flush_d = 1'b1;
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        misaligned_d = 1'b1;
                        if_valid_d   = 1'b0;
                        state_d      = S_HALT;
                    end
                end
            end

            S_HOLD: begin
                // Redirect wins over stall: the held instruction is squashed.
                if (redirect_valid_i) begin
                    if_valid_d = 1'b0;
                    if (target_aligned) begin
                        pc_d    = redirect_target_i;
                        flush_d = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        misaligned_d = 1'b1;
                        state_d      = S_HALT;
                    end
                end else if (!stall_i) begin
                    // Decode takes the instruction at this edge.
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end
            end

            S_HALT: begin
                // Terminal until reset; every input is ignored.
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_addr_o  = pc_q;
    assign if_valid_o   = if_valid_q;
    assign if_pc_o      = if_pc_q;
    assign if_instr_o   = if_instr_q;
    assign flush_o      = flush_q;
    assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_fetch_control.sv
module tb_fetch_control;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clock;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        misaligned;

    int checks;
    int failures;

    fetch_control #(.RESET_PC(RST_PC)) dut (
        .clock_i          (clock),
        .reset_n_i        (reset_n),
        .redirect_valid_i (redirect_valid),
        .redirect_target_i(redirect_target),
        .stall_i          (stall),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_ready_i     (imem_ready),
        .imem_rvalid_i    (imem_rvalid),
        .imem_rdata_i     (imem_rdata),
        .if_valid_o       (if_valid),
        .if_pc_o          (if_pc),
        .if_instr_o       (if_instr),
        .flush_o          (flush),
        .misaligned_o     (misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents used by the random test: a bijection of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic clear_inputs();
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        stall           = 1'b0;
        imem_ready      = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'h0;
    endtask

    // Reset for two cycles, release at a negedge (DUT is then in IDLE).
    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clock);
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%b exp=0", flush); end
        checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL rst_misaligned got=%b exp=0", misaligned); end
        checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL rst_if_pc got=%h exp=0", if_pc); end
        checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_if_instr got=%h exp=0", if_instr); end
        checks++; if (imem_addr !== RST_PC) begin failures++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RST_PC); end
        $display("reset: outputs idle, addr=%h", imem_addr);
    endtask

    task automatic test_first_fetch();
        @(negedge clock);
        reset_n    = 1'b1;
        imem_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req got=%b exp=0", imem_req); end
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin failures++; $display("FAIL first_req got=%b/%h exp=1/%h", imem_req, imem_addr, RST_PC); end
        @(negedge clock);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wait_req got=%b exp=0", imem_req); end
        @(negedge clock);
        imem_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== RST_PC || if_instr !== 32'h0050_0093) begin
            failures++; $display("FAIL first_present got=%b/%h/%h exp=1/%h/00500093", if_valid, if_pc, if_instr, RST_PC); end
        @(negedge clock);
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin
            failures++; $display("FAIL second_req got=%b/%b/%h exp=0/1/00000104", if_valid, imem_req, imem_addr); end
        $display("first_fetch: presented pc=%h instr=%h, next req %h", RST_PC, 32'h0050_0093, imem_addr);
    endtask

    // Entered with DUT in REQ at 0x104, imem_ready=0.
    task automatic test_stall_hold();
        imem_ready = 1'b1;
        @(negedge clock);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_0001;
        @(negedge clock);
        imem_rvalid = 1'b0;
        stall       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'h104 || if_instr !== 32'hCAFE_0001 || imem_req !== 1'b0) begin
                failures++; $display("FAIL stall_hold[%0d] got=%b/%h/%h req=%b exp=1/00000104/cafe0001 req=0", i, if_valid, if_pc, if_instr, imem_req); end
        end
        stall = 1'b0;
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h108 || if_valid !== 1'b0) begin
            failures++; $display("FAIL stall_release got=%b/%h/%b exp=1/00000108/0", imem_req, imem_addr, if_valid); end
        $display("stall_hold: held 5 cycles, next req %h", imem_addr);
    endtask

    // Entered with DUT in REQ at 0x108, imem_ready=0.
    task automatic test_redirect_wait();
        imem_ready = 1'b1;
        @(negedge clock);
        imem_ready      = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        @(negedge clock);
        redirect_valid = 1'b0;
        checks++; if (flush !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h200) begin
            failures++; $display("FAIL rw_flush got=%b/%b/%h exp=1/0/00000200", flush, imem_req, imem_addr); end
        @(negedge clock);
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rw_flush_width got=%b exp=0", flush); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clock);
        imem_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++; $display("FAIL rw_discard got=%b/%b/%h exp=0/1/00000200", if_valid, imem_req, imem_addr); end
        $display("redirect_wait: stale response dropped, req %h", imem_addr);
    endtask

    // Entered with DUT in REQ at 0x200, imem_ready=0.
    task automatic test_redirect_stall_hold();
        imem_ready = 1'b1;
        @(negedge clock);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00A0_0113;
        @(negedge clock);
        imem_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
            failures++; $display("FAIL rsh_present got=%b/%h exp=1/00000200", if_valid, if_pc); end
        stall           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        @(negedge clock);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || flush !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            failures++; $display("FAIL rsh_redirect got=%b/%b/%b/%h exp=0/1/1/00000040", if_valid, flush, imem_req, imem_addr); end
        @(negedge clock);
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rsh_flush_width got=%b exp=0", flush); end
        $display("redirect_stall_hold: redirect won, req %h", imem_addr);
    endtask

    // Entered with DUT in REQ at 0x40, imem_ready=0.
    task automatic test_back_to_back();
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL b2b_req_suppress got=%b exp=0", imem_req); end
        @(negedge clock);
        checks++; if (flush !== 1'b1 || imem_addr !== 32'h80) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/00000080", flush, imem_addr); end
        redirect_target = 32'hC0;
        @(negedge clock);
        checks++; if (flush !== 1'b1 || imem_addr !== 32'hC0) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/000000c0", flush, imem_addr); end
        redirect_valid = 1'b0;
        @(negedge clock);
        checks++; if (flush !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hC0) begin
            failures++; $display("FAIL b2b_after got=%b/%b/%h exp=0/1/000000c0", flush, imem_req, imem_addr); end
        $display("back_to_back: two pulses, req %h", imem_addr);
    endtask

    // Entered with DUT in REQ at 0xC0, imem_ready=0.
    task automatic test_wrap();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", imem_req, imem_addr); end
        imem_ready = 1'b1;
        @(negedge clock);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        @(negedge clock);
        imem_rvalid = 1'b0;
        checks++; if (if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h13) begin
            failures++; $display("FAIL wrap_present got=%h/%h exp=fffffffc/00000013", if_pc, if_instr); end
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || misaligned !== 1'b0) begin
            failures++; $display("FAIL wrap_next got=%b/%h/%b exp=1/00000000/0", imem_req, imem_addr, misaligned); end
        $display("wrap: next req %h", imem_addr);
    endtask

    // Entered with DUT in REQ at 0x0, imem_ready=0.
    task automatic test_misaligned();
        redirect_valid  = 1'b1;
        redirect_target = 32'h202;
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        checks++; if (misaligned !== 1'b1 || flush !== 1'b0 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
            failures++; $display("FAIL mis_enter got=%b/%b/%b/%b exp=1/0/0/0", misaligned, flush, imem_req, if_valid); end
        for (int i = 0; i < 6; i++) begin
            redirect_valid  = 1'b1;
            redirect_target = 32'h300;
            imem_ready      = 1'b1;
            imem_rvalid     = 1'($urandom_range(0, 1));
            #1;
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mis_req[%0d] got=%b exp=0", i, imem_req); end
            @(negedge clock);
            checks++; if (misaligned !== 1'b1 || flush !== 1'b0 || if_valid !== 1'b0) begin
                failures++; $display("FAIL mis_halt[%0d] got=%b/%b/%b exp=1/0/0", i, misaligned, flush, if_valid); end
        end
        clear_inputs();
        reset_n = 1'b0;
        #1;
        checks++; if (misaligned !== 1'b0 || imem_addr !== RST_PC) begin
            failures++; $display("FAIL mis_reset got=%b/%h exp=0/%h", misaligned, imem_addr, RST_PC); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            failures++; $display("FAIL mis_restart got=%b/%h exp=1/%h", imem_req, imem_addr, RST_PC); end
        $display("misaligned: halted, reset restarts at %h", imem_addr);
    endtask

    // Entered with DUT in REQ at RST_PC, imem_ready=0.
    task automatic test_reset_mid_wait();
        imem_ready = 1'b1;
        @(negedge clock);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_2222;
        @(negedge clock);
        imem_rvalid = 1'b0;
        @(negedge clock);
        imem_ready = 1'b1;
        @(negedge clock);
        imem_ready = 1'b0;   // now in WAIT, last instruction still in if_*
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0 || imem_req !== 1'b0 || imem_addr !== RST_PC) begin
            failures++; $display("FAIL rmw_clear got=%h/%h/%b/%h exp=0/0/0/%h", if_pc, if_instr, imem_req, imem_addr, RST_PC); end
        @(negedge clock);
        reset_n     = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3333_4444;
        @(negedge clock);
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            failures++; $display("FAIL rmw_req got=%b/%h exp=1/%h", imem_req, imem_addr, RST_PC); end
        @(negedge clock);
        imem_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1) begin
            failures++; $display("FAIL rmw_late_rvalid got=%b/%b exp=0/1", if_valid, imem_req); end
        $display("reset_mid_wait: cleared, late response ignored");
    endtask

    // ------------------------------------------------------------------
    // Random traffic checked against an architectural model: the expected
    // PC sequence, which responses are stale, and when flush must pulse.
    task automatic test_random();
        logic [31:0] arch_pc, exp_pc, exp_instr, req_addr, tgt;
        logic        exp_valid, exp_flush, outstanding, stale, accept, redir, rv, had_out;
        int          delay, since_accept, delivered;
        do_reset();
        arch_pc = RST_PC; exp_pc = 32'h0; exp_instr = 32'h0; req_addr = 32'h0;
        exp_valid = 1'b0; exp_flush = 1'b0; outstanding = 1'b0; stale = 1'b0;
        delay = 0; since_accept = 0; delivered = 0;
        @(negedge clock);   // skip the IDLE cycle
        for (int cyc = 0; cyc < 4000; cyc++) begin
            checks++; if (if_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, if_valid, exp_valid); end
            checks++; if (flush !== exp_flush) begin failures++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", cyc, flush, exp_flush); end
            checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL rnd_misaligned cyc=%0d got=%b exp=0", cyc, misaligned); end
            if (exp_valid) begin
                checks++; if (if_pc !== exp_pc || if_instr !== exp_instr) begin
                    failures++; $display("FAIL rnd_present cyc=%0d got=%h/%h exp=%h/%h", cyc, if_pc, if_instr, exp_pc, exp_instr); end
            end

            redir = ($urandom_range(0, 9) == 0);
            tgt   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            rv    = outstanding && (delay == 0);
            if (outstanding && delay > 0) delay--;
            redirect_valid  = redir;
            redirect_target = tgt;
            stall           = ($urandom_range(0, 2) == 0);
            imem_ready      = 1'($urandom_range(0, 1));
            imem_rvalid     = rv;
            imem_rdata      = rv ? mem_word(req_addr) : $urandom();
            #1;
            if (imem_req === 1'b1) begin
                checks++; if (imem_addr !== arch_pc) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, arch_pc); end
                checks++; if (outstanding || exp_valid || redir) begin
                    failures++; $display("FAIL rnd_req_busy cyc=%0d got=1 exp=0", cyc); end
            end
            accept = (imem_req === 1'b1) && imem_ready;

            // Architectural effect of this cycle, visible after the edge.
            had_out   = outstanding;
            exp_flush = redir;
            if (rv) outstanding = 1'b0;
            if (redir) begin
                exp_valid = 1'b0;
                arch_pc   = tgt;
                stale     = had_out && !rv;
            end else if (rv) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    exp_valid = 1'b1;
                    exp_pc    = arch_pc;
                    exp_instr = mem_word(arch_pc);
                    delivered++;
                end
            end else if (exp_valid && !stall) begin
                exp_valid = 1'b0;
                arch_pc   = arch_pc + 32'd4;
            end
            if (accept) begin
                outstanding  = 1'b1;
                req_addr     = imem_addr;
                delay        = $urandom_range(0, 3);
                since_accept = 0;
            end else begin
                since_accept++;
            end
            @(negedge clock);
            if (since_accept > 200) begin
                failures++; checks++;
                $display("FAIL rnd_watchdog cyc=%0d got=no_accept exp=accept_within_200", cyc);
                break;
            end
        end
        checks++; if (delivered < 50) begin failures++; $display("FAIL rnd_throughput got=%0d exp=>=50", delivered); end
        clear_inputs();
        $display("random: %0d instructions delivered", delivered);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_first_fetch();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_stall_hold();
        test_back_to_back();
        test_wrap();
        test_misaligned();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
